// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared definitions for the signed multiply/divide unit.
//   DATA_W      operand / result width
//   ITER_COUNT  iterations per multiply or divide
//   CNT_W       width of the iteration counter
//   state_t     FSM state encoding (IDLE, MULT, DIV, DONE)
//   abs_mag     two's-complement magnitude; -2^31 maps to unsigned 2^31
package mult_div_pkg;

  localparam int DATA_W     = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = $clog2(ITER_COUNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Magnitude as an unsigned DATA_W value. The most negative input wraps
  // onto itself, which read as unsigned is exactly its magnitude.
  function automatic logic [DATA_W-1:0] abs_mag(input logic [DATA_W-1:0] x);
    abs_mag = x[DATA_W-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/mult_div_div_step.sv
// div_step: one iteration of unsigned restoring division (combinational).
//   rem       current partial remainder (DATA_W+1 bits, always < dvs)
//   quo       dividend bits still to shift in (MSB first), quotient bits
//             fill in from the LSB
//   dvs       divisor magnitude (DATA_W+1 bits)
//   rem_next  partial remainder after the trial subtract / restore
//   quo_next  quo shifted left with the new quotient bit appended
module div_step
  import mult_div_pkg::*;
(
  input  logic [DATA_W:0]   rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W:0]   dvs,
  output logic [DATA_W:0]   rem_next,
  output logic [DATA_W-1:0] quo_next
);

  logic [DATA_W:0]   shifted;
  logic [DATA_W+1:0] trial;

  always_comb begin
    // rem < dvs <= 2^31, so rem's top bit is always clear and the shifted
    // value fits in DATA_W+1 bits.
    shifted = {rem[DATA_W-1:0], quo[DATA_W-1]};
    trial   = {1'b0, shifted} - {1'b0, dvs};
    if (trial[DATA_W+1]) begin
      // Borrow: divisor does not fit, keep (restore) the shifted remainder.
      rem_next = shifted;
      quo_next = {quo[DATA_W-2:0], 1'b0};
    end else begin
      rem_next = trial[DATA_W:0];
      quo_next = {quo[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div.sv
// mult_div: iterative signed 32x32 multiply (radix-2 Booth) and signed
// 32/32 divide (restoring), one iteration per clock, 32 iterations.
//   clk, reset           clock; synchronous active-high reset
//   start_mult/start_div one-cycle requests, honoured only in IDLE;
//                        multiply wins when both are high
//   a, b                 operands, sampled on the accepting edge
//   hi_out / lo_out      product[63:32]/[31:0], or remainder/quotient
//   busy                 high in MULT, DIV and DONE
//   done                 one-cycle pulse when hi_out/lo_out are valid
//   div_zero             set by a divide with b = 0, held until next start
//   fsm_state            current FSM state, for observation
//
// Handshake: a request is accepted on a rising edge where the unit is in
// IDLE and start_mult or start_div is high; there is no back-pressure and
// requests seen outside IDLE are dropped. Results appear on the edge that
// enters DONE and are held until the next completed operation or reset.
module mult_div
  import mult_div_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start_mult,
  input  logic              start_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output state_t            fsm_state
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;

  // Booth working accumulator {acc_hi, acc_lo, acc_q1} and multiplicand.
  logic [DATA_W-1:0] acc_hi;
  logic [DATA_W-1:0] acc_lo;
  logic              acc_q1;
  logic [DATA_W-1:0] mcand;

  // Division working registers and sign fix-up flags.
  logic [DATA_W:0]   rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W:0]   dvs;
  logic              neg_q;
  logic              neg_r;

  // Booth next-iteration values. The add/subtract is done one bit wider so
  // that subtracting a multiplicand of -2^31 cannot overflow before the
  // arithmetic shift.
  logic [DATA_W:0]   booth_sum;
  logic [DATA_W-1:0] booth_hi_next;
  logic [DATA_W-1:0] booth_lo_next;
  logic              booth_q1_next;

  always_comb begin
    booth_sum = {acc_hi[DATA_W-1], acc_hi};
    case ({acc_lo[0], acc_q1})
      2'b01:   booth_sum = {acc_hi[DATA_W-1], acc_hi} + {mcand[DATA_W-1], mcand};
      2'b10:   booth_sum = {acc_hi[DATA_W-1], acc_hi} - {mcand[DATA_W-1], mcand};
      default: booth_sum = {acc_hi[DATA_W-1], acc_hi};
    endcase
    booth_hi_next = booth_sum[DATA_W:1];
    booth_lo_next = {booth_sum[0], acc_lo[DATA_W-1:1]};
    booth_q1_next = acc_lo[0];
  end

  logic [DATA_W:0]   rem_next;
  logic [DATA_W-1:0] quo_next;
  logic [DATA_W-1:0] quo_fixed;
  logic [DATA_W-1:0] rem_fixed;

  div_step u_div_step (
    .rem      (rem),
    .quo      (quo),
    .dvs      (dvs),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_comb begin
    // 32-bit negation wraps 2^31 back to 0x80000000, which gives the
    // required -2^31 / -1 result without a special case.
    quo_fixed = neg_q ? (~quo_next + 1'b1) : quo_next;
    rem_fixed = neg_r ? (~rem_next[DATA_W-1:0] + 1'b1) : rem_next[DATA_W-1:0];
  end

  logic last_iter;
  assign last_iter = (cnt == CNT_W'(ITER_COUNT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      hi_out   <= '0;
      lo_out   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      acc_q1   <= 1'b0;
      mcand    <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mult) begin
            state    <= MULT;
            busy     <= 1'b1;
            cnt      <= '0;
            div_zero <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= b;
            acc_q1   <= 1'b0;
            mcand    <= a;
          end else if (start_div) begin
            busy <= 1'b1;
            cnt  <= '0;
            if (b == '0) begin
              // No iterations: flag and finish, results left untouched.
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state    <= DIV;
              div_zero <= 1'b0;
              rem      <= '0;
              quo      <= abs_mag(a);
              dvs      <= {1'b0, abs_mag(b)};
              neg_q    <= a[DATA_W-1] ^ b[DATA_W-1];
              neg_r    <= a[DATA_W-1];
            end
          end
        end

        MULT: begin
          acc_hi <= booth_hi_next;
          acc_lo <= booth_lo_next;
          acc_q1 <= booth_q1_next;
          cnt    <= cnt + 1'b1;
          if (last_iter) begin
            hi_out <= booth_hi_next;
            lo_out <= booth_lo_next;
            state  <= DONE;
            done   <= 1'b1;
          end
        end

        DIV: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            hi_out <= rem_fixed;
            lo_out <= quo_fixed;
            state  <= DONE;
            done   <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 clk  input  1  system clock; all state SHALL change on the rising edge only.
REQ-002 reset  input  1  reset, synchronous, active-high.
REQ-003 start_mult  input  1  one-cycle request from the control unit for a signed multiply of a by b.
REQ-004 start_div  input  1  one-cycle request from the control unit for a signed divide of a by b.
REQ-005 a  input  32  operand A (multiplicand / dividend), two's complement; sampled only on the accepting edge.
REQ-006 b  input  32  operand B (multiplier / divisor), two's complement; sampled only on the accepting edge.
REQ-007 hi_out  output  32  HI register: product bits 63:32, or division remainder.
REQ-008 lo_out  output  32  LO register: product bits 31:0, or division quotient.
REQ-009 busy  output  1  high while an operation is in progress (states MULT, DIV, DONE).
REQ-010 done  output  1  single-cycle pulse marking HI/LO valid.
REQ-011 div_zero  output  1  registered flag set by a divide with b = 0; held until the next accepted start.

Function
REQ-012 The FSM SHALL have states IDLE, MULT, DIV and DONE, with encodings from the shared package.
REQ-013 In IDLE, start_mult=1 SHALL capture a and b, clear the iteration counter and div_zero, and go to MULT.
REQ-014 In IDLE, start_div=1 with start_mult=0 and b!=0 SHALL capture a and b, clear div_zero, and go to DIV.
REQ-015 If start_mult and start_div are both high in IDLE, multiply SHALL win and the divide request SHALL be dropped.
REQ-016 start_div with b=0 SHALL go straight to DONE with div_zero=1; hi_out and lo_out SHALL stay unchanged.
REQ-017 Start requests outside IDLE SHALL be ignored, with no effect on the operation or the outputs.
REQ-018 MULT SHALL run radix-2 Booth for exactly 32 iterations, one per cycle, on a 65-bit accumulator {HI, LO, q-1}; each shift is arithmetic.
REQ-019 DIV SHALL run 32-iteration unsigned restoring division on |a| and |b|, using 33-bit magnitudes so that -2^31 is exact.
REQ-020 Divide sign fix-up: the quotient SHALL be negated when sign(a) XOR sign(b); the remainder SHALL take the sign of a.
REQ-021 0x80000000 / 0xFFFFFFFF SHALL yield lo_out=0x80000000 and hi_out=0 (wrap), with no flag.
REQ-022 hi_out and lo_out SHALL be written on the edge that completes iteration 32, which is also the edge that enters DONE.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 Latency: done SHALL be high in the 33rd cycle after the accepting edge; the div-by-zero case SHALL raise done in the 1st cycle.
REQ-025 A new start SHALL be accepted in the first IDLE cycle after DONE; back-to-back operations SHALL therefore be 34 cycles apart.
REQ-026 hi_out and lo_out SHALL hold their last result indefinitely; intermediate iterations SHALL NOT be visible on them.

Reset
REQ-027 reset=1 at any edge SHALL force IDLE and clear hi_out, lo_out, busy, done, div_zero and the counter, even mid-operation.
REQ-028 reset SHALL take priority over start_mult and start_div on the same edge.
REQ-029 The first start SHALL be accepted on the first edge with reset=0.

Structure
REQ-030 Package mult_div_pkg SHALL hold the state typedef/encoding, ITER_COUNT=32 and DATA_W=32.
REQ-031 One combinational sub-module, div_step, SHALL implement a single restoring-division iteration (trial subtract plus select).
REQ-032 Booth logic SHALL stay inline in mult_div.

Verification
REQ-033 Multiply: a=7, b=-3 -> after 33 cycles, done=1, hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB.
REQ-034 Multiply: a=b=0x80000000 -> hi_out=0x40000000, lo_out=0x00000000.
REQ-035 Divide: a=-7, b=2 -> lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1), div_zero=0.
REQ-036 Divide by zero: a=5, b=0 after a prior result -> done next cycle, div_zero=1, hi_out and lo_out unchanged.
REQ-037 Start while busy: start_div pulsed at cycle 10 of a multiply -> multiply result correct, exactly one done pulse.
REQ-038 Reset mid-operation: reset at cycle 15 of a divide -> next cycle all outputs 0, state IDLE, no done pulse.
